// File: rtl/pg_egreedy_param_if.sv
// Handshake and data bundle between the Q-matrix reader, the epsilon-greedy
// policy block and the environment/reward consumer.
interface pg_egreedy_param_if #(
    parameter int N_AGENT = 2,
    parameter int N_ACT   = 4,
    parameter int QW      = 32,
    parameter int EPS_W   = 8
);
    localparam int AW = $clog2(N_ACT);

    logic                        in_valid;
    logic                        in_ready;
    logic [N_AGENT*N_ACT*QW-1:0] q_flat;
    logic                        learning;
    logic [EPS_W-1:0]            eps;
    logic                        out_valid;
    logic                        out_ready;
    logic [N_AGENT*AW-1:0]       a_flat;
    logic [N_AGENT*AW-1:0]       amax_flat;
    logic [N_AGENT*AW-1:0]       amin_flat;
    logic [N_AGENT-1:0]          explore;

    modport master (
        output in_valid, q_flat, learning, eps, out_ready,
        input  in_ready, out_valid, a_flat, amax_flat, amin_flat, explore
    );

    modport slave (
        input  in_valid, q_flat, learning, eps, out_ready,
        output in_ready, out_valid, a_flat, amax_flat, amin_flat, explore
    );
endinterface

// File: rtl/pg_egreedy_param.sv
// Epsilon-greedy action selection for N_AGENT agents: one action per cycle
// signed argmax/argmin scan plus a per-agent Galois LFSR for exploration.
module pg_egreedy_param #(
    parameter int          N_AGENT = 2,
    parameter int          N_ACT   = 4,
    parameter int          QW      = 32,
    parameter int          EPS_W   = 8,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input logic               clk,
    input logic               rst,
    pg_egreedy_param_if.slave bus
);
    localparam int AW = $clog2(N_ACT);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                state_q;
    logic signed [QW-1:0]  q_q       [N_AGENT][N_ACT];
    logic signed [QW-1:0]  bestMax_q [N_AGENT];
    logic signed [QW-1:0]  bestMin_q [N_AGENT];
    logic [AW-1:0]         idxMax_q  [N_AGENT];
    logic [AW-1:0]         idxMin_q  [N_AGENT];
    logic [15:0]           lfsr_q    [N_AGENT];
    logic [EPS_W-1:0]      rndHi_q   [N_AGENT];
    logic [AW-1:0]         rndLo_q   [N_AGENT];
    logic                  learn_q;
    logic [EPS_W-1:0]      eps_q;
    logic [AW-1:0]         idx_q;
    logic                  outValid_q;
    logic [N_AGENT*AW-1:0] a_q;
    logic [N_AGENT*AW-1:0] amax_q;
    logic [N_AGENT*AW-1:0] amin_q;
    logic [N_AGENT-1:0]    explore_q;

    logic signed [QW-1:0]  bestMax_d [N_AGENT];
    logic signed [QW-1:0]  bestMin_d [N_AGENT];
    logic [AW-1:0]         idxMax_d  [N_AGENT];
    logic [AW-1:0]         idxMin_d  [N_AGENT];
    logic [N_AGENT-1:0]    exploreHit_d;

    function automatic logic [15:0] lfsrStep(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    // Agent i starts from SEED rotated left by i bits.
    function automatic logic [15:0] seedOf(input int i);
        logic [31:0] dbl;
        dbl = {SEED, SEED};
        return dbl[31 - (i % 16) -: 16];
    endfunction

    // Strict compares keep the lowest index on ties.
    always_comb begin
        for (int g = 0; g < N_AGENT; g++) begin
            bestMax_d[g] = bestMax_q[g];
            bestMin_d[g] = bestMin_q[g];
            idxMax_d[g]  = idxMax_q[g];
            idxMin_d[g]  = idxMin_q[g];
            if (q_q[g][idx_q] > bestMax_q[g]) begin
                bestMax_d[g] = q_q[g][idx_q];
                idxMax_d[g]  = idx_q;
            end
            if (q_q[g][idx_q] < bestMin_q[g]) begin
                bestMin_d[g] = q_q[g][idx_q];
                idxMin_d[g]  = idx_q;
            end
            exploreHit_d[g] = learn_q && (rndHi_q[g] < eps_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            learn_q    <= 1'b0;
            eps_q      <= '0;
            idx_q      <= '0;
            outValid_q <= 1'b0;
            a_q        <= '0;
            amax_q     <= '0;
            amin_q     <= '0;
            explore_q  <= '0;
            for (int g = 0; g < N_AGENT; g++) begin
                lfsr_q[g]    <= seedOf(g);
                rndHi_q[g]   <= '0;
                rndLo_q[g]   <= '0;
                bestMax_q[g] <= '0;
                bestMin_q[g] <= '0;
                idxMax_q[g]  <= '0;
                idxMin_q[g]  <= '0;
                for (int k = 0; k < N_ACT; k++) q_q[g][k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        learn_q <= bus.learning;
                        eps_q   <= bus.eps;
                        idx_q   <= AW'(1);
                        state_q <= SCAN;
                        for (int g = 0; g < N_AGENT; g++) begin
                            for (int k = 0; k < N_ACT; k++)
                                q_q[g][k] <= bus.q_flat[(g*N_ACT + k)*QW +: QW];
                            bestMax_q[g] <= bus.q_flat[g*N_ACT*QW +: QW];
                            bestMin_q[g] <= bus.q_flat[g*N_ACT*QW +: QW];
                            idxMax_q[g]  <= '0;
                            idxMin_q[g]  <= '0;
                            rndHi_q[g]   <= lfsr_q[g][15 -: EPS_W];
                            rndLo_q[g]   <= lfsr_q[g][AW-1:0];
                            lfsr_q[g]    <= lfsrStep(lfsr_q[g]);
                        end
                    end
                end
                SCAN: begin
                    idx_q <= idx_q + AW'(1);
                    for (int g = 0; g < N_AGENT; g++) begin
                        bestMax_q[g] <= bestMax_d[g];
                        bestMin_q[g] <= bestMin_d[g];
                        idxMax_q[g]  <= idxMax_d[g];
                        idxMin_q[g]  <= idxMin_d[g];
                    end
                    // The last action's compare feeds the outputs on this same edge.
                    if (idx_q == AW'(N_ACT - 1)) begin
                        state_q    <= DONE;
                        outValid_q <= 1'b1;
                        explore_q  <= exploreHit_d;
                        for (int g = 0; g < N_AGENT; g++) begin
                            amax_q[g*AW +: AW] <= idxMax_d[g];
                            amin_q[g*AW +: AW] <= idxMin_d[g];
                            a_q[g*AW +: AW]    <= exploreHit_d[g] ? rndLo_q[g] : idxMax_d[g];
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = outValid_q;
    assign bus.a_flat    = a_q;
    assign bus.amax_flat = amax_q;
    assign bus.amin_flat = amin_q;
    assign bus.explore   = explore_q;
endmodule

// File: tb/tb_pg_egreedy_param.sv
// Directed bench for pg_egreedy_param: reset, greedy/signed scans, exploration
// against an LFSR model, backpressure and mid-operation reset.
module tb_pg_egreedy_param;
    localparam int N_AGENT = 2;
    localparam int N_ACT   = 4;
    localparam int QW      = 32;
    localparam int EPS_W   = 8;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] mLfsr [N_AGENT];

    // Agent vectors packed as {q3,q2,q1,q0}.
    localparam logic [127:0] G0 = {32'd7, 32'd12, -32'd3, 32'd5};
    localparam logic [127:0] G1 = {-32'd1, -32'd1, 32'd0, 32'd0};
    localparam logic [127:0] S0 = {32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    localparam logic [127:0] S1 = {4{32'd7}};
    localparam logic [127:0] E0 = {32'd3, 32'd2, 32'd4, 32'd1};
    localparam logic [127:0] E1 = {-32'd1, -32'd9, -32'd2, -32'd5};

    always #5 clk = ~clk;

    pg_egreedy_param_if #(.N_AGENT(N_AGENT), .N_ACT(N_ACT), .QW(QW), .EPS_W(EPS_W)) bus ();

    pg_egreedy_param #(.N_AGENT(N_AGENT), .N_ACT(N_ACT), .QW(QW), .EPS_W(EPS_W), .SEED(16'hACE1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [15:0] modelStep(input logic [15:0] x);
        logic [15:0] s;
        s = {1'b0, x[15:1]};
        if (x[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    task automatic driveVec(input logic [127:0] ag0, input logic [127:0] ag1,
                            input logic lrn, input logic [7:0] e);
        bus.q_flat   = {ag1, ag0};
        bus.learning = lrn;
        bus.eps      = e;
    endtask

    task automatic acceptVec(input logic [127:0] ag0, input logic [127:0] ag1,
                             input logic lrn, input logic [7:0] e);
        @(negedge clk);
        driveVec(ag0, ag1, lrn, e);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic waitOut(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++;
        if ({bus.a_flat, bus.amax_flat, bus.amin_flat, bus.explore} !== 14'h0)
            begin errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", {bus.a_flat, bus.amax_flat, bus.amin_flat, bus.explore}); end
    endtask

    task automatic test_greedy();
        int lat;
        acceptVec(G0, G1, 1'b0, 8'hFF);
        waitOut(lat);
        checks++;
        if (lat !== 3) begin errors++; $display("[TB] FAIL greedy_latency: got %0d expected 3", lat); end
        checks++;
        if (bus.a_flat !== 4'b0010) begin errors++; $display("[TB] FAIL greedy_a: got %h expected 2", bus.a_flat); end
        checks++;
        if (bus.amax_flat !== 4'b0010) begin errors++; $display("[TB] FAIL greedy_amax: got %h expected 2", bus.amax_flat); end
        checks++;
        if (bus.amin_flat !== 4'b1001) begin errors++; $display("[TB] FAIL greedy_amin: got %h expected 9", bus.amin_flat); end
        checks++;
        if (bus.explore !== 2'b00) begin errors++; $display("[TB] FAIL greedy_explore: got %b expected 00", bus.explore); end
        consume();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL greedy_release: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_signed_tie();
        int lat;
        acceptVec(S0, S1, 1'b0, 8'h00);
        waitOut(lat);
        checks++;
        if (bus.amax_flat !== 4'b0001) begin errors++; $display("[TB] FAIL signed_amax: got %h expected 1", bus.amax_flat); end
        checks++;
        if (bus.amin_flat !== 4'b0000) begin errors++; $display("[TB] FAIL signed_amin: got %h expected 0", bus.amin_flat); end
        checks++;
        if (bus.a_flat !== 4'b0001) begin errors++; $display("[TB] FAIL signed_a: got %h expected 1", bus.a_flat); end
        consume();
    endtask

    task automatic test_eps_zero();
        int lat;
        acceptVec(G0, G1, 1'b1, 8'h00);
        waitOut(lat);
        checks++;
        if (bus.explore !== 2'b00) begin errors++; $display("[TB] FAIL eps0_explore: got %b expected 00", bus.explore); end
        checks++;
        if (bus.a_flat !== 4'b0010) begin errors++; $display("[TB] FAIL eps0_a: got %h expected 2", bus.a_flat); end
        consume();
    endtask

    task automatic test_explore();
        int lat;
        logic [15:0] rnd;
        logic [1:0]  expExp;
        logic [3:0]  expA;
        logic [1:0]  amax [N_AGENT];
        amax[0] = 2'd1;
        amax[1] = 2'd3;
        doReset();
        mLfsr[0] = 16'hACE1;
        mLfsr[1] = {mLfsr[0][14:0], mLfsr[0][15]};
        for (int i = 0; i < 10; i++) begin
            for (int g = 0; g < N_AGENT; g++) begin
                rnd = mLfsr[g];
                mLfsr[g] = modelStep(mLfsr[g]);
                expExp[g] = (rnd[15:8] < 8'hFF);
                expA[g*2 +: 2] = expExp[g] ? rnd[1:0] : amax[g];
            end
            acceptVec(E0, E1, 1'b1, 8'hFF);
            waitOut(lat);
            checks++;
            if (bus.explore !== expExp) begin errors++; $display("[TB] FAIL explore_flag[%0d]: got %b expected %b", i, bus.explore, expExp); end
            checks++;
            if (bus.a_flat !== expA) begin errors++; $display("[TB] FAIL explore_a[%0d]: got %h expected %h", i, bus.a_flat, expA); end
            if (i == 0) begin
                checks++;
                if ({bus.explore, bus.a_flat} !== 6'b11_1101)
                    begin errors++; $display("[TB] FAIL explore_seed: got %b expected 111101", {bus.explore, bus.a_flat}); end
            end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        acceptVec(G0, G1, 1'b0, 8'h00);
        waitOut(lat);
        driveVec(S0, S1, 1'b0, 8'h00);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.a_flat, bus.amin_flat} !== 10'b10_0010_1001)
                begin errors++; $display("[TB] FAIL hold[%0d]: got %b expected 1000101001", c, {bus.out_valid, bus.in_ready, bus.a_flat, bus.amin_flat}); end
        end
        consume();
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.a_flat} !== 6'b01_0010)
            begin errors++; $display("[TB] FAIL release: got %b expected 010010", {bus.out_valid, bus.in_ready, bus.a_flat}); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL second_accept: got %b expected 0", bus.in_ready); end
        waitOut(lat);
        checks++;
        if (lat !== 3) begin errors++; $display("[TB] FAIL second_latency: got %0d expected 3", lat); end
        checks++;
        if ({bus.amax_flat, bus.amin_flat} !== 8'b0001_0000)
            begin errors++; $display("[TB] FAIL second_result: got %b expected 00010000", {bus.amax_flat, bus.amin_flat}); end
        consume();
    endtask

    task automatic test_midop_reset();
        int lat;
        acceptVec(G0, G1, 1'b1, 8'h80);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.a_flat, bus.amax_flat, bus.amin_flat, bus.explore} !== 16'h4000)
            begin errors++; $display("[TB] FAIL abort_state: got %h expected 4000", {bus.out_valid, bus.in_ready, bus.a_flat, bus.amax_flat, bus.amin_flat, bus.explore}); end
        acceptVec(G0, G1, 1'b1, 8'h80);
        waitOut(lat);
        checks++;
        if (lat !== 3) begin errors++; $display("[TB] FAIL rerun_latency: got %0d expected 3", lat); end
        checks++;
        if ({bus.a_flat, bus.explore} !== 6'b1110_10)
            begin errors++; $display("[TB] FAIL rerun_a_explore: got %b expected 111010", {bus.a_flat, bus.explore}); end
        checks++;
        if ({bus.amax_flat, bus.amin_flat} !== 8'b0010_1001)
            begin errors++; $display("[TB] FAIL rerun_amax_amin: got %b expected 00101001", {bus.amax_flat, bus.amin_flat}); end
        consume();
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        driveVec('0, '0, 1'b0, 8'h00);
        test_reset();
        test_greedy();
        test_signed_tie();
        test_eps_zero();
        test_explore();
        test_back_to_back();
        test_midop_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
